// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster generator.
// Produces DrawX/DrawY coordinates, the active-video flag (blank), active-low
// hs/vs sync pulses and a one-cycle frame_start pulse after each frame wrap.
// All sync/blank outputs are decoded from the next-state counters and
// registered, so they are cycle-aligned with DrawX/DrawY.
// Optional build macro VGA_SYNC_ALIGN_EN: hs/vs/blank pass through a
// SYNC_DELAY-deep shift register to line up with drawers that use a sync ROM
// plus an output register. DrawX/DrawY/frame_start are never delayed.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Decode boundaries are 11 bits wide so a sync window ending at 1024 still compares correctly.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (SYNC_DELAY < 1)) begin : g_param_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024 and SYNC_DELAY >= 1");
    end

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
    logic [10:0] x_ext, y_ext;

    // Next raster position and sync/blank decode of that next position.
    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
                y_d = '0;
            end else begin
                y_d = y_q + 10'd1;
            end
        end
        x_ext         = {1'b0, x_d};
        y_ext         = {1'b0, y_d};
        hs_d          = !((x_ext >= HS_START) && (x_ext < HS_END));
        vs_d          = !((y_ext >= VS_START) && (y_ext < VS_END));
        blank_d       = (x_ext < H_VIS) && (y_ext < V_VIS);
        // 0,0 is only reached through the counters by a frame wrap; reset bypasses this path.
        frame_start_d = (x_d == '0) && (y_d == '0);
    end

    // Counter and decoded-output registers; reset overrides counting.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign frame_start = frame_start_q;

`ifdef VGA_SYNC_ALIGN_EN
    logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d;
    logic [SYNC_DELAY-1:0] vs_dly_q, vs_dly_d;
    logic [SYNC_DELAY-1:0] blank_dly_q, blank_dly_d;

    // Shift the registered sync/blank values one stage per cycle.
    always_comb begin
        hs_dly_d       = hs_dly_q;
        vs_dly_d       = vs_dly_q;
        blank_dly_d    = blank_dly_q;
        hs_dly_d[0]    = hs_q;
        vs_dly_d[0]    = vs_q;
        blank_dly_d[0] = blank_q;
        for (int unsigned i = 1; i < SYNC_DELAY; i++) begin
            hs_dly_d[i]    = hs_dly_q[i-1];
            vs_dly_d[i]    = vs_dly_q[i-1];
            blank_dly_d[i] = blank_dly_q[i-1];
        end
    end

    // Delay stages clear to the idle sync/blank levels so no stale pulse survives reset.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_dly_q    <= '1;
            vs_dly_q    <= '1;
            blank_dly_q <= '0;
        end else begin
            hs_dly_q    <= hs_dly_d;
            vs_dly_q    <= vs_dly_d;
            blank_dly_q <= blank_dly_d;
        end
    end

    assign hs    = hs_dly_q[SYNC_DELAY-1];
    assign vs    = vs_dly_q[SYNC_DELAY-1];
    assign blank = blank_dly_q[SYNC_DELAY-1];
`else
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
`endif

endmodule
